// File: rtl/sdr_pkg.sv
//============================================================================
// Module      : sdr_pkg
// Description : Shared constants and types for the multi-channel IQ upstream
//               path: packet sync byte, header field layout, the framing FSM
//               state encoding and the output skid-buffer entry format.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

package sdr_pkg;

  // Output word width toward the FT600 write FSM.
  localparam int WORD_W = 32;

  // Header word layout: {SYNC[31:24], CH[23:20], SEQ[19:8], 8'h00}.
  localparam logic [7:0] PKT_SYNC     = 8'hA5;
  localparam int         HDR_SYNC_LSB = 24;
  localparam int         HDR_SYNC_W   = 8;
  localparam int         HDR_CH_LSB   = 20;
  localparam int         HDR_CH_W     = 4;
  localparam int         HDR_SEQ_LSB  = 8;
  localparam int         HDR_SEQ_W    = 12;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  // One word waiting in the output skid buffer, with its framing markers.
  typedef struct packed {
    logic [WORD_W-1:0] data;
    logic              sop;
    logic              eop;
  } skid_entry_t;

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
//============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin search. Grants the first requesting
//               channel at or after ptr_i, searching upward and wrapping.
//               The pointer itself is registered by the caller.
// Ports       : req_i       - per-channel request bits
//               ptr_i       - search start index
//               grant_o     - one-hot grant (zero when nothing requests)
//               grant_idx_o - binary index of the granted channel
//               valid_o     - at least one request present
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module rr_arbiter #(
  parameter int NUM_CH = 2,
  parameter int IDX_W  = 1
) (
  input  logic [NUM_CH-1:0] req_i,
  input  logic [IDX_W-1:0]  ptr_i,
  output logic [NUM_CH-1:0] grant_o,
  output logic [IDX_W-1:0]  grant_idx_o,
  output logic              valid_o
);

  logic w_found;

  // Two ordered passes: first the channels at/above the pointer, then the
  // ones below it. The first hit in that order wins.
  always_comb begin
    w_found     = 1'b0;
    grant_o     = '0;
    grant_idx_o = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (!w_found && req_i[c] && (IDX_W'(c) >= ptr_i)) begin
        w_found     = 1'b1;
        grant_o[c]  = 1'b1;
        grant_idx_o = IDX_W'(c);
      end
    end
    for (int c = 0; c < NUM_CH; c++) begin
      if (!w_found && req_i[c] && (IDX_W'(c) < ptr_i)) begin
        w_found     = 1'b1;
        grant_o[c]  = 1'b1;
        grant_idx_o = IDX_W'(c);
      end
    end
    valid_o = w_found;
  end

endmodule

`default_nettype wire

// File: rtl/iq_stream_mux.sv
//============================================================================
// Module      : iq_stream_mux
// Description : Merges NUM_CH IQ FIFO streams into one framed 32-bit word
//               stream for the FT600 write FSM (ft_clk domain). Channels are
//               served round-robin, one packet at a time: a header word
//               {A5, ch, seq, 00} followed by PKT_WORDS sign-extended IQ words.
// Ports       : clk, reset_n           - ft_clk, async-assert active-low reset
//               ch_en/ch_enough        - per-channel eligibility inputs
//               ch_empty/ch_data/ch_rd - FIFO interfaces (Q valid 1 cycle
//                                        after ch_rd)
//               pkt_*                  - valid/ready framed output stream
//               busy                   - a packet is in progress
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module iq_stream_mux
  import sdr_pkg::*;
#(
  parameter int NUM_CH        = 2,
  parameter int IQ_PAIR_WIDTH = 24,
  parameter int FT_DATA_WIDTH = 32,
  parameter int PKT_WORDS     = 32,
  parameter int SEQ_WIDTH     = 12
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic [NUM_CH-1:0]               ch_en,
  input  logic [NUM_CH-1:0]               ch_enough,
  input  logic [NUM_CH-1:0]               ch_empty,
  input  logic [NUM_CH*IQ_PAIR_WIDTH-1:0] ch_data,
  output logic [NUM_CH-1:0]               ch_rd,
  output logic [FT_DATA_WIDTH-1:0]        pkt_data,
  output logic                            pkt_valid,
  output logic                            pkt_sop,
  output logic                            pkt_eop,
  input  logic                            pkt_ready,
  output logic                            busy
);

  localparam int IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int CNT_W  = $clog2(PKT_WORDS + 1);
  localparam int HALF_W = IQ_PAIR_WIDTH / 2;

  state_t                state_q, state_d;
  logic [IDX_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]      gidx_q, gidx_d;
  logic [NUM_CH-1:0]     goh_q, goh_d;
  logic [CNT_W-1:0]      rd_cnt_q, rd_cnt_d;
  logic                  inflight_q, inflight_eop_q;
  skid_entry_t           buf_q [2];
  skid_entry_t           buf_d [2];
  logic [1:0]            occ_q, occ_d;
  logic [SEQ_WIDTH-1:0]  seq_q [NUM_CH];

  logic [NUM_CH-1:0]     w_arb_oh;
  logic [IDX_W-1:0]      w_arb_idx;
  logic                  w_arb_valid;
  logic                  w_pop;
  logic [1:0]            w_occ_eff;
  logic [2:0]            w_slots_used;
  logic                  w_hdr_push;
  logic                  w_rd_fire;
  logic                  w_push;
  logic                  w_grant_empty;
  skid_entry_t           w_push_entry;
  logic [WORD_W-1:0]     w_hdr_word;
  logic [WORD_W-1:0]     w_data_word;
  logic [IQ_PAIR_WIDTH-1:0] w_q_sel;
  logic signed [HALF_W-1:0] w_i_raw, w_q_raw;
  logic signed [15:0]    w_i16, w_q16;

  //--------------------------------------------------------------------------
  // Arbitration
  //--------------------------------------------------------------------------
  rr_arbiter #(
    .NUM_CH (NUM_CH),
    .IDX_W  (IDX_W)
  ) u_arb (
    .req_i       (ch_en & ch_enough),
    .ptr_i       (rr_ptr_q),
    .grant_o     (w_arb_oh),
    .grant_idx_o (w_arb_idx),
    .valid_o     (w_arb_valid)
  );

  //--------------------------------------------------------------------------
  // Credit / skid-buffer flow control
  //--------------------------------------------------------------------------
  assign pkt_valid     = (occ_q != 2'd0);
  assign w_pop         = pkt_valid & pkt_ready;
  // Occupancy after this cycle's pop: lets a read issue in the same cycle a
  // word leaves, which is what sustains 1 word/cycle.
  assign w_occ_eff     = occ_q - {1'b0, w_pop};
  assign w_grant_empty = |(ch_empty & goh_q);

  // Buffer is always empty on HDR entry (previous eop already accepted), so
  // the header push normally succeeds on the first HDR cycle.
  assign w_hdr_push   = (state_q == ST_HDR) && (w_occ_eff == 2'd0) && !inflight_q;
  assign w_slots_used = {1'b0, w_occ_eff} + {2'b00, inflight_q} + {2'b00, w_hdr_push};

  // The first data read may issue alongside the header push so the header is
  // followed by data without a bubble.
  assign w_rd_fire = (((state_q == ST_HDR) && w_hdr_push) || (state_q == ST_DATA))
                     && (rd_cnt_q < CNT_W'(PKT_WORDS))
                     && !w_grant_empty
                     && (w_slots_used < 3'd2);

  assign ch_rd = goh_q & {NUM_CH{w_rd_fire}};

  //--------------------------------------------------------------------------
  // Word formation
  //--------------------------------------------------------------------------
  always_comb begin
    w_q_sel = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (gidx_q == IDX_W'(i)) begin
        w_q_sel = ch_data[i*IQ_PAIR_WIDTH +: IQ_PAIR_WIDTH];
      end
    end
  end

  assign w_i_raw     = w_q_sel[IQ_PAIR_WIDTH-1:HALF_W];
  assign w_q_raw     = w_q_sel[HALF_W-1:0];
  assign w_i16       = 16'(w_i_raw);
  assign w_q16       = 16'(w_q_raw);
  assign w_data_word = {w_i16, w_q16};

  always_comb begin
    w_hdr_word                              = '0;
    w_hdr_word[HDR_SYNC_LSB +: HDR_SYNC_W]  = PKT_SYNC;
    w_hdr_word[HDR_CH_LSB   +: HDR_CH_W]    = HDR_CH_W'(gidx_q);
    w_hdr_word[HDR_SEQ_LSB  +: HDR_SEQ_W]   = HDR_SEQ_W'(seq_q[gidx_q]);
  end

  assign w_push = w_hdr_push | inflight_q;

  always_comb begin
    if (w_hdr_push) begin
      w_push_entry = '{data: w_hdr_word, sop: 1'b1, eop: 1'b0};
    end else begin
      w_push_entry = '{data: w_data_word, sop: 1'b0, eop: inflight_eop_q};
    end
  end

  //--------------------------------------------------------------------------
  // Skid buffer: entry 0 is the head driven onto the output
  //--------------------------------------------------------------------------
  always_comb begin
    buf_d[0] = buf_q[0];
    buf_d[1] = buf_q[1];
    if (w_pop) begin
      buf_d[0] = buf_q[1];
    end
    if (w_push) begin
      buf_d[w_occ_eff[0]] = w_push_entry;
    end
    occ_d = w_occ_eff + {1'b0, w_push};
  end

  assign pkt_data = buf_q[0].data;
  assign pkt_sop  = pkt_valid & buf_q[0].sop;
  assign pkt_eop  = pkt_valid & buf_q[0].eop;
  assign busy     = (state_q != ST_IDLE);

  //--------------------------------------------------------------------------
  // FSM next state
  //--------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    gidx_d   = gidx_q;
    goh_d    = goh_q;
    rd_cnt_d = rd_cnt_q;
    if (w_rd_fire) begin
      rd_cnt_d = rd_cnt_q + 1'b1;
    end
    case (state_q)
      ST_IDLE: begin
        rd_cnt_d = '0;
        if (w_arb_valid) begin
          gidx_d  = w_arb_idx;
          goh_d   = w_arb_oh;
          state_d = ST_HDR;
        end
      end
      ST_HDR: begin
        if (w_hdr_push) begin
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (w_pop && buf_q[0].eop) begin
          state_d  = ST_IDLE;
          rr_ptr_d = (gidx_q == IDX_W'(NUM_CH - 1)) ? '0 : gidx_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  //--------------------------------------------------------------------------
  // Registers
  //--------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr_q       <= '0;
      gidx_q         <= '0;
      goh_q          <= '0;
      rd_cnt_q       <= '0;
      inflight_q     <= 1'b0;
      inflight_eop_q <= 1'b0;
      occ_q          <= '0;
      buf_q[0]       <= '0;
      buf_q[1]       <= '0;
    end else begin
      rr_ptr_q       <= rr_ptr_d;
      gidx_q         <= gidx_d;
      goh_q          <= goh_d;
      rd_cnt_q       <= rd_cnt_d;
      inflight_q     <= w_rd_fire;
      inflight_eop_q <= w_rd_fire && (rd_cnt_q == CNT_W'(PKT_WORDS - 1));
      occ_q          <= occ_d;
      buf_q[0]       <= buf_d[0];
      buf_q[1]       <= buf_d[1];
    end
  end

  // Sequence advances when the header is accepted by the host side, so a
  // header lost to reset before acceptance does not consume a number.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        seq_q[i] <= '0;
      end
    end else if (w_pop && buf_q[0].sop) begin
      seq_q[gidx_q] <= seq_q[gidx_q] + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_iq_stream_mux.sv
//============================================================================
// Module      : tb_iq_stream_mux
// Description : Self-checking bench for iq_stream_mux. FIFO models feed the
//               channels; expected output words are queued per channel when
//               samples are written and compared as framed words emerge.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module tb_iq_stream_mux;

  localparam int NCH = 2;
  localparam int W   = 24;
  localparam int PW  = 8;
  localparam int NWRAP_PKTS = 4097;

  logic             clk = 1'b0;
  logic             reset_n;
  logic [NCH-1:0]   ch_en, ch_enough, ch_empty, ch_rd;
  logic [NCH*W-1:0] ch_data;
  logic [31:0]      pkt_data;
  logic             pkt_valid, pkt_sop, pkt_eop, pkt_ready, busy;

  always #5 clk = ~clk;

  iq_stream_mux #(
    .NUM_CH        (NCH),
    .IQ_PAIR_WIDTH (W),
    .FT_DATA_WIDTH (32),
    .PKT_WORDS     (PW),
    .SEQ_WIDTH     (12)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .ch_en     (ch_en),
    .ch_enough (ch_enough),
    .ch_empty  (ch_empty),
    .ch_data   (ch_data),
    .ch_rd     (ch_rd),
    .pkt_data  (pkt_data),
    .pkt_valid (pkt_valid),
    .pkt_sop   (pkt_sop),
    .pkt_eop   (pkt_eop),
    .pkt_ready (pkt_ready),
    .busy      (busy)
  );

  // FIFO contents and per-channel expected output words
  logic [W-1:0]  fifo [NCH][$];
  logic [31:0]   expq [NCH][$];

  int            n_err = 0;
  int            n_chk = 0;

  // Reference model of framing state
  int            m_ptr;
  logic [11:0]   m_seq [NCH];
  int            m_ch;
  bit            m_in_pkt;
  int            m_cnt;
  int            pkt_done;
  bit            after_eop;
  int            force_empty_cyc;
  int            ready_pct;
  logic [NCH-1:0] rd_s;
  bit            hold_v;
  logic [33:0]   hold_w;
  int            outst;
  bit            track_outst;
  bit            gap_seen;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] sx(input logic [W-1:0] w);
    return {{4{w[23]}}, w[23:12], {4{w[11]}}, w[11:0]};
  endfunction

  task automatic push_word(input int ch, input logic [W-1:0] w, input logic [31:0] e);
    fifo[ch].push_back(w);
    expq[ch].push_back(e);
  endtask

  task automatic push_rand(input int ch, input int n);
    logic [W-1:0] w;
    for (int k = 0; k < n; k++) begin
      w = W'($urandom());
      push_word(ch, w, sx(w));
    end
  endtask

  function automatic int pick_ch();
    int c;
    for (int k = 0; k < NCH; k++) begin
      c = (m_ptr + k) % NCH;
      if (ch_en[c] && (expq[c].size() >= PW)) return c;
    end
    return -1;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < NCH; i++) begin
      fifo[i].delete();
      expq[i].delete();
      m_seq[i] = '0;
    end
    m_ptr = 0; m_ch = 0; m_in_pkt = 0; m_cnt = 0;
    after_eop = 0; hold_v = 0; outst = 0; rd_s = '0;
  endtask

  // Output-side monitor, evaluated away from the active edge
  task automatic monitor_sample();
    logic [31:0] e;
    rd_s = ch_rd;
    if (ch_rd != '0) check_eq("rd_onehot", $countones(ch_rd), 1);
    if (after_eop) begin
      check_eq("idle_busy", busy, 1'b0);
      after_eop = 0;
    end
    if (hold_v) check_eq("hold_stable", {pkt_valid, pkt_sop, pkt_eop, pkt_data}, {1'b1, hold_w});
    hold_v = pkt_valid & !pkt_ready;
    hold_w = {pkt_sop, pkt_eop, pkt_data};
    if (m_in_pkt && !pkt_valid) gap_seen = 1;
    if (track_outst && ch_rd != '0) outst++;
    if (pkt_valid && pkt_ready) begin
      if (pkt_sop) begin
        check_eq("sop_position", m_in_pkt, 1'b0);
        m_ch = pick_ch();
        check_eq("hdr_eligible", (m_ch >= 0), 1'b1);
        if (m_ch < 0) m_ch = int'(pkt_data[23:20]) % NCH;
        check_eq("hdr_word", pkt_data, {8'hA5, 4'(m_ch), m_seq[m_ch], 8'h00});
        check_eq("hdr_eop", pkt_eop, 1'b0);
        m_seq[m_ch] = m_seq[m_ch] + 12'd1;
        m_in_pkt = 1;
        m_cnt = 0;
      end else begin
        check_eq("data_in_pkt", m_in_pkt, 1'b1);
        check_eq("data_avail", (expq[m_ch].size() > 0), 1'b1);
        if (expq[m_ch].size() > 0) begin
          e = expq[m_ch].pop_front();
          check_eq("data_word", pkt_data, e);
        end
        if (track_outst) outst--;
        m_cnt++;
        check_eq("eop_marker", pkt_eop, (m_cnt == PW));
        if (pkt_eop) begin
          m_in_pkt = 0;
          m_ptr = (m_ch + 1) % NCH;
          pkt_done++;
          after_eop = 1;
        end
      end
    end
    if (track_outst) check_eq("outstanding_le2", (outst <= 2), 1'b1);
  endtask

  // FIFO side: apply reads sampled before the edge, refresh flags and ready
  task automatic drive_inputs();
    for (int i = 0; i < NCH; i++) begin
      if (rd_s[i]) begin
        check_eq("rd_nonempty", (fifo[i].size() > 0), 1'b1);
        if (fifo[i].size() > 0) ch_data[i*W +: W] = fifo[i].pop_front();
      end
    end
    for (int i = 0; i < NCH; i++) begin
      ch_empty[i]  = (fifo[i].size() == 0) || (force_empty_cyc > 0);
      ch_enough[i] = (fifo[i].size() >= PW);
    end
    if (force_empty_cyc > 0) force_empty_cyc--;
    pkt_ready = ($urandom_range(0, 99) < ready_pct);
  endtask

  initial begin : p_env
    forever begin
      @(negedge clk);
      monitor_sample();
      @(posedge clk);
      #1;
      drive_inputs();
    end
  end

  task automatic wait_pkts(input int n, input int budget);
    int target;
    target = pkt_done + n;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk); #2;
      if (pkt_done >= target) break;
    end
    check_eq("pkt_count", pkt_done, target);
  endtask

  task automatic wait_word(input int idx, input int budget);
    bit hit;
    hit = 0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk); #2;
      if (m_in_pkt && m_cnt == idx) begin
        hit = 1;
        break;
      end
    end
    check_eq("reach_word", hit, 1'b1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_valid"}, pkt_valid, 1'b0);
    check_eq({tag, "_sop"},   pkt_sop,   1'b0);
    check_eq({tag, "_eop"},   pkt_eop,   1'b0);
    check_eq({tag, "_busy"},  busy,      1'b0);
    check_eq({tag, "_rd"},    ch_rd,     '0);
    check_eq({tag, "_data"},  pkt_data,  '0);
  endtask

  initial begin : p_main
    logic [W-1:0] w;
    reset_n = 1'b0;
    ch_en = '0; ch_enough = '0; ch_empty = '1; ch_data = '0; pkt_ready = 1'b1;
    ready_pct = 100; force_empty_cyc = 0; pkt_done = 0;
    track_outst = 0; gap_seen = 0;
    model_clear();

    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    reset_n = 1'b1;

    // 1: ch0 has two packets' worth, ch1 too little to be eligible
    @(negedge clk); #2;
    push_rand(0, 2 * PW);
    push_rand(1, 3);
    ch_en = 2'b11;
    wait_pkts(2, 200);

    // 2: both channels eligible throughout -> alternation
    push_rand(0, 3 * PW);
    push_rand(1, 3 * PW - 3);
    wait_pkts(6, 600);

    // 3: sign-extension corner
    ch_en = 2'b01;
    push_word(0, 24'h800_7FF, 32'hF800_07FF);
    push_rand(0, PW - 1);
    wait_pkts(1, 100);

    // 4: 30% ready duty, both channels
    ready_pct = 30; outst = 0; track_outst = 1;
    ch_en = 2'b11;
    push_rand(0, 2 * PW);
    push_rand(1, 2 * PW);
    wait_pkts(4, 3000);
    ready_pct = 100; track_outst = 0;

    // 5: FIFO underflow mid-packet
    ch_en = 2'b01;
    push_rand(0, PW);
    wait_word(3, 100);
    gap_seen = 0;
    force_empty_cyc = 5;
    wait_pkts(1, 100);
    check_eq("underflow_gap", gap_seen, 1'b1);

    // 6: reset mid-packet, then seq wrap on ch0
    push_rand(0, PW);
    wait_word(5, 100);
    reset_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    model_clear();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    #2;
    for (int k = 0; k < NWRAP_PKTS * PW; k++) begin
      w = W'($urandom());
      push_word(0, w, sx(w));
    end
    wait_pkts(NWRAP_PKTS, NWRAP_PKTS * 12 + 200);
    check_eq("wrap_seq_next", m_seq[0], 12'd1);
    check_eq("drain_exp0", expq[0].size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
